// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the debug FSM encoding, forward-select codes and the counter helper.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HALTED = 2'b01,
    STEP   = 2'b10
  } hc_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int CNT_W = 16;

  // Saturating increment: the event counters stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward select for one execute-stage ALU operand.
// Memory stage wins over writeback; register x0 is never forwarded.
module hazard_fwd_sel
  import hazard_controller_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i);
  assign hit_w = reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (hit_m)      fwd_o = FWD_MEM;
    else if (hit_w) fwd_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard unit with debug halt/single-step and event counters.
// Forwarding and stall/flush are combinational; FSM state and counters are registered.
//
// state  | meaning
// RUN    | normal execution, hazard logic drives stall/flush
// HALTED | debug halt: fetch/decode frozen, execute bubbled, halt_ack high
// STEP   | one cycle of normal execution released from HALTED
module hazard_controller
  import hazard_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 ResultSrcE,
  input  logic                 PCSrcE,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 cnt_clr,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 halt_ack,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  hc_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall;

  hazard_fwd_sel u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardAE)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardBE)
  );

  assign lw_stall = ResultSrcE && RegWriteE && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // A taken branch squashes the load-use victim, so it beats the stall.
  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    halt_ack = 1'b0;
    if (state_q == HALTED) begin
      StallF   = 1'b1;
      StallD   = 1'b1;
      FlushE   = 1'b1;
      halt_ack = 1'b1;
    end else begin
      StallF = lw_stall && !PCSrcE;
      StallD = lw_stall && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = PCSrcE || lw_stall;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req && !lw_stall && !PCSrcE) state_d = HALTED;
      HALTED: begin
        if (!halt_req)     state_d = RUN;
        else if (step_req) state_d = STEP;
      end
      STEP:    state_d = halt_req ? HALTED : RUN;
      default: state_d = RUN;
    endcase
  end

  // Halt-induced stalls are excluded; only hazard stalls are counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallD && (state_q != HALTED)) stall_cnt_d = sat_inc(stall_cnt_q);
      if (FlushD)                        flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table for the hazard logic,
// hand sequences for halt/step, saturation, clear and reset, counters via scoreboard.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE;
  logic        halt_req, step_req, cnt_clr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, halt_ack;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .halt_req(halt_req), .step_req(step_req), .cnt_clr(cnt_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .halt_ack(halt_ack), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    string      nm;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww, rse, pcs;
    logic [1:0] fa, fb;
    logic       st, fd, fe;
  } vec_t;

  typedef struct {
    logic [15:0] stall;
    logic [15:0] flush;
  } cnt_t;

  vec_t        vecs[12];
  cnt_t        sb[$];
  logic [15:0] m_stall, m_flush;
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(input string nm,
      input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
      input logic rwe, rwm, rww, rse, pcs,
      input logic [1:0] fa, fb, input logic st, fd, fe);
    vec_t v;
    v.nm = nm; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.rse = rse; v.pcs = pcs;
    v.fa = fa; v.fb = fb; v.st = st; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    halt_req = 0; step_req = 0; cnt_clr = 0;
  endtask

  task automatic set_vec(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    ResultSrcE = v.rse; PCSrcE = v.pcs;
  endtask

  task automatic set_lw();
    ResultSrcE = 1; RegWriteE = 1; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  // Called just after an edge with inputs set: checks this cycle's
  // combinational outputs, queues the counter values due after the next edge.
  task automatic run_cycle(input string nm, input logic [1:0] efa, efb,
                           input logic est, efd, efe, eha);
    cnt_t e;
    #1;
    chk({nm, ".fa"}, 16'(ForwardAE), 16'(efa));
    chk({nm, ".fb"}, 16'(ForwardBE), 16'(efb));
    chk({nm, ".stallF"}, 16'(StallF), 16'(est));
    chk({nm, ".stallD"}, 16'(StallD), 16'(est));
    chk({nm, ".flushD"}, 16'(FlushD), 16'(efd));
    chk({nm, ".flushE"}, 16'(FlushE), 16'(efe));
    chk({nm, ".halt_ack"}, 16'(halt_ack), 16'(eha));
    e.stall = cnt_clr ? 16'd0 : ((est && !eha) ? sat(m_stall) : m_stall);
    e.flush = cnt_clr ? 16'd0 : (efd ? sat(m_flush) : m_flush);
    m_stall = e.stall;
    m_flush = e.flush;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, ".sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, ".stall_cnt"}, stall_cnt, e.stall);
      chk({nm, ".flush_cnt"}, flush_cnt, e.flush);
    end
  endtask

  initial begin
    vecs[0]  = mk("idle",      0, 0, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b00, 2'b00, 0,0,0);
    vecs[1]  = mk("fwdA_mem",  0, 0, 5, 0, 0, 5, 5,  0,1,1,0,0, 2'b10, 2'b00, 0,0,0);
    vecs[2]  = mk("fwdA_wb",   0, 0, 5, 0, 0, 0, 5,  0,1,1,0,0, 2'b01, 2'b00, 0,0,0);
    vecs[3]  = mk("fwdB_wb",   0, 0, 0, 9, 0, 9, 9,  0,0,1,0,0, 2'b00, 2'b01, 0,0,0);
    vecs[4]  = mk("fwd_x0",    0, 0, 0, 0, 0, 0, 0,  0,1,1,0,0, 2'b00, 2'b00, 0,0,0);
    vecs[5]  = mk("fwdAB_mem", 0, 0, 3, 3, 0, 3, 3,  0,1,1,0,0, 2'b10, 2'b10, 0,0,0);
    vecs[6]  = mk("lw_rs2",    0, 7, 0, 0, 7, 0, 0,  1,0,0,1,0, 2'b00, 2'b00, 1,0,1);
    vecs[7]  = mk("lw_nowr",  12, 0, 0, 0,12, 0, 0,  0,0,0,1,0, 2'b00, 2'b00, 0,0,0);
    vecs[8]  = mk("lw_x0",     0, 0, 0, 0, 0, 0, 0,  1,0,0,1,0, 2'b00, 2'b00, 0,0,0);
    vecs[9]  = mk("branch",    0, 0, 0, 0, 0, 0, 0,  0,0,0,0,1, 2'b00, 2'b00, 0,1,1);
    vecs[10] = mk("lw_branch", 7, 0, 0, 0, 7, 0, 0,  1,0,0,1,1, 2'b00, 2'b00, 0,1,1);
    vecs[11] = mk("alu_dep",   7, 0, 0, 0, 7, 0, 0,  1,0,0,0,0, 2'b00, 2'b00, 0,0,0);

    clr_in();
    rst = 1'b0;
    m_stall = 16'd0;
    m_flush = 16'd0;
    #2;
    chk("reset.halt_ack", 16'(halt_ack), 16'd0);
    chk("reset.stall_cnt", stall_cnt, 16'd0);
    chk("reset.flush_cnt", flush_cnt, 16'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      clr_in();
      set_vec(vecs[i]);
      run_cycle(vecs[i].nm, vecs[i].fa, vecs[i].fb, vecs[i].st, vecs[i].fd, vecs[i].fe, 1'b0);
    end

    // Halt, single step, re-halt.
    clr_in();
    halt_req = 1;
    run_cycle("halt_enter", 2'b00, 2'b00, 0, 0, 0, 0);
    set_lw();
    run_cycle("halted_lw", 2'b00, 2'b00, 1, 0, 1, 1);
    clr_in(); halt_req = 1; step_req = 1;
    run_cycle("halted_step", 2'b00, 2'b00, 1, 0, 1, 1);
    step_req = 0;
    run_cycle("step", 2'b00, 2'b00, 0, 0, 0, 0);
    run_cycle("rehalt", 2'b00, 2'b00, 1, 0, 1, 1);

    // Asynchronous reset mid-cycle while halted.
    Rs1E = 5; RdM = 5; RegWriteM = 1;
    #3 rst = 1'b0;
    halt_req = 0;
    #1;
    chk("rst_halt.halt_ack", 16'(halt_ack), 16'd0);
    chk("rst_halt.stallF", 16'(StallF), 16'd0);
    chk("rst_halt.fa", 16'(ForwardAE), 16'b10);
    chk("rst_halt.stall_cnt", stall_cnt, 16'd0);
    chk("rst_halt.flush_cnt", flush_cnt, 16'd0);
    m_stall = 16'd0;
    m_flush = 16'd0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Halt request blocked by a load-use hazard until it clears.
    clr_in(); halt_req = 1; set_lw();
    run_cycle("halt_blk", 2'b00, 2'b00, 1, 0, 1, 0);
    clr_in(); halt_req = 1;
    run_cycle("halt_go", 2'b00, 2'b00, 0, 0, 0, 0);
    halt_req = 0;
    run_cycle("halt_rel", 2'b00, 2'b00, 1, 0, 1, 1);
    run_cycle("run_again", 2'b00, 2'b00, 0, 0, 0, 0);

    // Saturation of stall_cnt, then clear overriding a same-cycle stall.
    clr_in(); set_lw();
    repeat (65535) @(posedge clk);
    #1;
    m_stall = 16'hFFFF;
    chk("sat.stall_cnt", stall_cnt, m_stall);
    run_cycle("sat_hold", 2'b00, 2'b00, 1, 0, 1, 0);
    cnt_clr = 1;
    run_cycle("clr", 2'b00, 2'b00, 1, 0, 1, 0);
    cnt_clr = 0;
    run_cycle("after_clr", 2'b00, 2'b00, 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
